// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with PC register, IF/ID register and fetch counter.
// Build option: define IF_MISALIGN_CHECK_EN to word-align redirect targets
// and pulse fetch_misalign one cycle after a misaligned redirect.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset
//   stall          hazard hold (PC and IF/ID frozen)
//   redirect_valid taken branch/jump from EX
//   redirect_pc    byte address of redirect target
//   current_pc     byte address to instruction memory (combinational read)
//   instr          word returned by memory for current_pc
//   ifid_valid     IF/ID holds a real instruction
//   ifid_pc        PC of the IF/ID instruction
//   ifid_instr     IF/ID instruction, NOP when not valid
//   fetch_count    instructions delivered to IF/ID, saturating
//   fetch_misalign one-cycle misaligned-redirect flag
module instr_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [9:0]  redirect_pc,
   output logic [9:0]  current_pc,
   input  logic [31:0] instr,
   output logic        ifid_valid,
   output logic [9:0]  ifid_pc,
   output logic [31:0] ifid_instr,
   output logic [15:0] fetch_count,
   output logic        fetch_misalign
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state;
   logic [9:0]  redirect_target;
   logic        redirect_misalign;

`ifdef IF_MISALIGN_CHECK_EN
   assign redirect_target   = {redirect_pc[9:2], 2'b00};
   assign redirect_misalign = |redirect_pc[1:0];
`else
   assign redirect_target   = redirect_pc;
   assign redirect_misalign = 1'b0;
`endif

   // BOOT spends one cycle with PC at 0 and captures nothing, so memory
   // can settle before the first word is latched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         current_pc  <= '0;
         ifid_valid  <= 1'b0;
         ifid_pc     <= '0;
         ifid_instr  <= NOP;
         fetch_count <= '0;
      end else begin
         unique case (state)
            BOOT: begin
               state <= RUN;
            end
            RUN: begin
               if (redirect_valid) begin
                  current_pc <= redirect_target;
                  ifid_valid <= 1'b0;
                  ifid_instr <= NOP;
               end else if (!stall) begin
                  ifid_pc    <= current_pc;
                  ifid_instr <= instr;
                  ifid_valid <= 1'b1;
                  current_pc <= current_pc + 10'd4;
                  if (fetch_count != 16'hFFFF)
                     fetch_count <= fetch_count + 16'd1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

`ifdef IF_MISALIGN_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset)
         fetch_misalign <= 1'b0;
      else
         fetch_misalign <= (state == RUN) && redirect_valid
                           && redirect_misalign;
   end
`else
   // redirect_misalign is constant 0 here; flag is tied low.
   assign fetch_misalign = redirect_misalign;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed and random stimulus for instr_fetch,
// checked every cycle against a behavioural model of the fetch rules.
module tb_instr_fetch;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_MISALIGN_CHECK_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [9:0]  redirect_pc;
   logic [9:0]  current_pc;
   logic [31:0] instr;
   logic        ifid_valid;
   logic [9:0]  ifid_pc;
   logic [31:0] ifid_instr;
   logic [15:0] fetch_count;
   logic        fetch_misalign;

   logic [31:0] mem [256];

   int n_checks = 0;
   int n_errs   = 0;
   bit check_en = 0;

   // behavioural model state
   bit          m_boot = 1;
   int          m_pc   = 0;
   bit          m_v    = 0;
   int          m_ipc  = 0;
   logic [31:0] m_ins  = NOP;
   int          m_cnt  = 0;
   bit          m_mis  = 0;

   instr_fetch dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .current_pc     (current_pc),
      .instr          (instr),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_instr     (ifid_instr),
      .fetch_count    (fetch_count),
      .fetch_misalign (fetch_misalign)
   );

   assign instr = mem[current_pc[9:2]];

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Reference: next-state of the fetch unit from its stated rules.
   always @(posedge clk) begin
      if (reset) begin
         m_boot = 1; m_pc = 0; m_v = 0; m_ipc = 0;
         m_ins = NOP; m_cnt = 0; m_mis = 0;
      end else if (m_boot) begin
         m_boot = 0;
         m_mis  = 0;
      end else if (redirect_valid) begin
         if (MIS_EN) begin
            m_pc  = int'(redirect_pc) / 4 * 4;
            m_mis = (int'(redirect_pc) % 4) != 0;
         end else begin
            m_pc  = int'(redirect_pc);
            m_mis = 0;
         end
         m_v   = 0;
         m_ins = NOP;
      end else if (stall) begin
         m_mis = 0;
      end else begin
         m_ipc = m_pc;
         m_ins = mem[m_pc / 4];
         m_v   = 1;
         m_pc  = (m_pc + 4) % 1024;
         m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         m_mis = 0;
      end
   end

   // Single compare process, away from the active edge.
   always @(negedge clk) begin
      if (check_en) begin
         chk("m_current_pc", 32'(current_pc), 32'(m_pc));
         chk("m_ifid_valid", 32'(ifid_valid), 32'(m_v));
         chk("m_ifid_pc", 32'(ifid_pc), 32'(m_ipc));
         chk("m_ifid_instr", ifid_instr, m_ins);
         chk("m_fetch_count", 32'(fetch_count), 32'(m_cnt));
         chk("m_fetch_misalign", 32'(fetch_misalign), 32'(m_mis));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0]   = 32'h0050_0113;
      mem[1]   = 32'h0031_0193;
      mem[16]  = 32'h00A0_0093;
      mem[255] = 32'h0010_0073;
      reset = 1; stall = 0; redirect_valid = 0; redirect_pc = '0;

      // reset state
      tick(2);
      chk("rst_pc", 32'(current_pc), 32'd0);
      chk("rst_valid", 32'(ifid_valid), 32'd0);
      chk("rst_instr", ifid_instr, NOP);
      chk("rst_count", 32'(fetch_count), 32'd0);
      chk("rst_mis", 32'(fetch_misalign), 32'd0);
      check_en = 1;
      reset = 0;

      // boot sequence
      tick(1);
      chk("boot_pc", 32'(current_pc), 32'd0);
      chk("boot_valid", 32'(ifid_valid), 32'd0);
      tick(1);
      chk("f0_instr", ifid_instr, 32'h0050_0113);
      chk("f0_pc", 32'(ifid_pc), 32'd0);
      tick(1);
      chk("f1_instr", ifid_instr, 32'h0031_0193);
      chk("f1_pc", 32'(ifid_pc), 32'd4);
      chk("f1_count", 32'(fetch_count), 32'd2);
      chk("f1_cur", 32'(current_pc), 32'd8);

      // stall at pc 8
      stall = 1;
      tick(3);
      chk("st_pc", 32'(current_pc), 32'd8);
      chk("st_ifid_pc", 32'(ifid_pc), 32'd4);
      chk("st_instr", ifid_instr, 32'h0031_0193);
      chk("st_count", 32'(fetch_count), 32'd2);
      stall = 0;
      tick(1);
      chk("st_rel_pc", 32'(current_pc), 32'd12);
      chk("st_rel_cnt", 32'(fetch_count), 32'd3);

      // redirect beats stall
      redirect_valid = 1; redirect_pc = 10'h040; stall = 1;
      tick(1);
      chk("rd_pc", 32'(current_pc), 32'h40);
      chk("rd_valid", 32'(ifid_valid), 32'd0);
      chk("rd_instr", ifid_instr, NOP);
      chk("rd_ifid_pc", 32'(ifid_pc), 32'd8);
      redirect_valid = 0; stall = 0;
      tick(1);
      chk("rd_cap", ifid_instr, 32'h00A0_0093);
      chk("rd_cap_pc", 32'(ifid_pc), 32'h40);

      // misaligned redirect
      redirect_valid = 1; redirect_pc = 10'h042;
      tick(1);
      chk("mis_pc", 32'(current_pc), MIS_EN ? 32'h40 : 32'h42);
      chk("mis_flag", 32'(fetch_misalign), MIS_EN ? 32'd1 : 32'd0);
      redirect_valid = 0;
      tick(1);
      chk("mis_flag_drop", 32'(fetch_misalign), 32'd0);

      // wrap at 1020
      redirect_valid = 1; redirect_pc = 10'd1020;
      tick(1);
      redirect_valid = 0;
      tick(1);
      chk("wrap_pc", 32'(current_pc), 32'd0);
      chk("wrap_ifid_pc", 32'(ifid_pc), 32'd1020);
      chk("wrap_instr", ifid_instr, 32'h0010_0073);

      // mid-run reset with pending redirect and stall
      redirect_valid = 1; redirect_pc = 10'h020;
      tick(1);
      redirect_valid = 0;
      chk("pre_rst_pc", 32'(current_pc), 32'h20);
      reset = 1; redirect_valid = 1; redirect_pc = 10'h080; stall = 1;
      tick(1);
      chk("mr_pc", 32'(current_pc), 32'd0);
      chk("mr_count", 32'(fetch_count), 32'd0);
      chk("mr_valid", 32'(ifid_valid), 32'd0);
      reset = 0; redirect_valid = 0; stall = 0;
      tick(1);
      chk("mr_boot_valid", 32'(ifid_valid), 32'd0);
      chk("mr_boot_pc", 32'(current_pc), 32'd0);
      tick(1);
      chk("mr_f0_valid", 32'(ifid_valid), 32'd1);
      chk("mr_f0_instr", ifid_instr, 32'h0050_0113);
      chk("mr_f0_count", 32'(fetch_count), 32'd1);

      // random phase
      for (int c = 0; c < 3000; c++) begin
         reset          = ($urandom_range(0, 99) < 1);
         stall          = ($urandom_range(0, 99) < 25);
         redirect_valid = ($urandom_range(0, 99) < 10);
         redirect_pc    = 10'($urandom);
         tick(1);
      end
      reset = 0; stall = 0; redirect_valid = 0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errs);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock; all state updates on this edge.
- reset  input  1  synchronous active-high reset.
REQ-002 stall  input  1  hazard hold; freezes PC and IF/ID register.
REQ-003 redirect_valid  input  1  taken branch/jump from EX; replaces next PC.
REQ-004 redirect_pc  input  10  byte address of the redirect target.
REQ-005 current_pc  output  10  byte address driven to instruction memory; the read is combinational.
REQ-006 instr  input  32  little-endian word returned by instruction memory for current_pc in the same cycle.
REQ-007 ifid_valid  output  1  IF/ID register holds a real instruction.
REQ-008 ifid_pc  output  10  PC of the instruction in IF/ID.
REQ-009 ifid_instr  output  32  instruction in IF/ID; 32'h00000013 (NOP) when ifid_valid=0.
REQ-010 fetch_count  output  16  number of instructions delivered into IF/ID; saturates at 16'hFFFF.
REQ-011 fetch_misalign  output  1  one-cycle flag for a misaligned redirect (see Configuration).

Function
REQ-012 The FSM SHALL have two states, BOOT and RUN:
- reset forces BOOT.
- BOOT moves to RUN on the first edge with reset=0.
- RUN holds until reset.
REQ-013 In BOOT, the block SHALL hold current_pc at 0 and capture nothing, because memory contents settle during this cycle; ifid_valid stays 0.
REQ-014 Update priority on each edge in RUN SHALL be reset > redirect_valid > stall > normal advance.
REQ-015 On a normal advance:
- ifid_pc <= current_pc.
- ifid_instr <= instr.
- ifid_valid <= 1.
- current_pc <= current_pc+4, modulo 1024 (1020 wraps to 0).
REQ-016 On redirect_valid=1:
- current_pc <= redirect_pc.
- IF/ID is flushed: ifid_valid=0, ifid_instr=NOP, ifid_pc unchanged.
- This applies even when stall=1 in the same cycle.
REQ-017 On stall=1 with no redirect, current_pc, ifid_pc, ifid_instr and ifid_valid SHALL hold unchanged.
REQ-018 Fetch latency SHALL be one cycle: a word presented at current_pc appears in IF/ID after the next rising edge.
REQ-019 fetch_count SHALL increment only on an edge that sets ifid_valid to 1 through a normal advance, and SHALL hold at 16'hFFFF.
REQ-020 The block SHALL contain no combinational path from instr to current_pc.

Reset
REQ-021 While reset=1, the following SHALL hold on each edge:
- FSM=BOOT.
- current_pc=0.
- ifid_valid=0, ifid_pc=0, ifid_instr=32'h00000013.
- fetch_count=0.
- fetch_misalign=0.
REQ-022 Reset asserted mid-run SHALL discard any pending redirect or stall, and fetch SHALL restart from address 0 via BOOT.

Configuration
REQ-023 The macro IF_MISALIGN_CHECK_EN SHALL select the misalign handling.
- Defined: a redirect with redirect_pc[1:0]!=0 loads {redirect_pc[9:2],2'b00}, and fetch_misalign is registered high for exactly one cycle after that edge.
- Undefined: redirect_pc loads verbatim, and fetch_misalign is tied to 0.
- The port SHALL exist in both builds.

Verification
REQ-024 Boot: reset for 2 cycles with memory at 0 = 0x00500113 and at 4 = 0x00310193, then release. Required response:
- BOOT cycle: current_pc=0, ifid_valid=0.
- Next edge: ifid_instr=0x00500113, ifid_pc=0.
- Next edge: ifid_instr=0x00310193, ifid_pc=4, fetch_count=2.
REQ-025 Stall: assert stall for 3 cycles at current_pc=8. Required response: current_pc stays 8, IF/ID is unchanged, and fetch_count is frozen; after release, PC advances to 12.
REQ-026 Redirect with stall: redirect_valid=1, redirect_pc=0x40 and stall=1 on the same edge. Required response: current_pc=0x40, ifid_valid=0, ifid_instr=0x00000013; the next edge captures the word at 0x40.
REQ-027 Wrap: run to current_pc=1020. Required response: the next advance gives current_pc=0 and ifid_pc=1020.
REQ-028 Misalign: redirect_pc=0x42.
- With IF_MISALIGN_CHECK_EN: current_pc=0x40 and a one-cycle fetch_misalign pulse.
- Without it: current_pc=0x42 and fetch_misalign=0.
REQ-029 Mid-run reset: reset asserted for one cycle at current_pc=0x20 with a redirect pending. Required response: current_pc=0, fetch_count=0, ifid_valid=0, then a BOOT cycle before fetch resumes.
